weight_memory_writer: RTL and testbench

Packs a serial stream of signed filter weights into N_ROWS_ARRAY-lane words and writes them into the weight memory that feeds `f_weight_array_reg`, one word per memory address. It is the write-side counterpart of the weight read path. Lane `j` of each written word lands at bits `[(j+1)*F_WIDTH-1 : j*F_WIDTH]`, which is the lane that reaches systolic-array row `j`. Sequencing is a valid/ready stream input, an FSM session with a start pulse and a done pulse, and registered memory-write outputs.

---
 rtl/weight_memory_writer.sv | 115 +++++++++++
 tb/tb_weight_memory_writer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_memory_writer.sv
// Packs a serial stream of signed weights into N_ROWS_ARRAY-lane words and
// writes one word per address into the weight memory feeding the systolic array.
module weight_memory_writer #(
  parameter int unsigned N_ROWS_ARRAY = 9,
  parameter int unsigned F_WIDTH      = 8,
  parameter int unsigned ADDRS_WIDTH  = 10
) (
  input  logic                              clk_i,
  input  logic                              rd_weight_rst,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [ADDRS_WIDTH-1:0]            base_addr_i,
  input  logic [ADDRS_WIDTH-1:0]            n_words_i,
  input  logic [F_WIDTH-1:0]                w_data_i,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  output logic                              wr_en_o,
  output logic [ADDRS_WIDTH-1:0]            wr_addr_o,
  output logic [F_WIDTH*N_ROWS_ARRAY-1:0]   wr_data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [ADDRS_WIDTH-1:0]            word_count_o
);

  localparam int unsigned LANE_W = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_ROWS_ARRAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_LAST, S_DONE} state_t;

  state_t state, state_nxt;

  logic [N_ROWS_ARRAY-1:0][F_WIDTH-1:0] lanes;
  logic [N_ROWS_ARRAY-1:0][F_WIDTH-1:0] word_c;
  logic [LANE_W-1:0]                    lane;
  logic [ADDRS_WIDTH-1:0]               base_q;
  logic [ADDRS_WIDTH-1:0]               n_words_q;
  logic [ADDRS_WIDTH-1:0]               word_idx;
  logic                                 accept_c;
  logic                                 word_done_c;
  logic                                 last_word_c;
  logic                                 start_ok_c;

  // Abort takes priority over a same-cycle accept, so the weight is dropped.
  assign w_ready_o   = (state == S_FILL);
  assign accept_c    = (state == S_FILL) && w_valid_i && !abort_i;
  assign word_done_c = accept_c && (lane == LAST_LANE);
  assign last_word_c = (word_idx == n_words_q - ADDRS_WIDTH'(1));
  assign start_ok_c  = (state == S_IDLE) && start_i;

  // Completed word: buffered lanes plus the weight arriving this cycle on the top lane.
  always_comb begin
    word_c            = lanes;
    word_c[LAST_LANE] = w_data_i;
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i) state_nxt = (n_words_i != '0) ? S_FILL : S_DONE;
      S_FILL: begin
        if (abort_i)                         state_nxt = S_IDLE;
        else if (word_done_c && last_word_c) state_nxt = S_LAST;
      end
      S_LAST:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      word_count_o <= '0;
      lanes        <= '0;
      lane         <= '0;
      base_q       <= '0;
      n_words_q    <= '0;
      word_idx     <= '0;
    end else begin
      busy_o  <= (state_nxt != S_IDLE);
      done_o  <= (state_nxt == S_DONE);
      wr_en_o <= 1'b0;
      if (start_ok_c) begin
        base_q       <= base_addr_i;
        n_words_q    <= n_words_i;
        lane         <= '0;
        word_idx     <= '0;
        word_count_o <= '0;
      end
      if (accept_c) begin
        lanes[lane] <= w_data_i;
        if (word_done_c) begin
          lane         <= '0;
          word_idx     <= word_idx + ADDRS_WIDTH'(1);
          wr_en_o      <= 1'b1;
          wr_addr_o    <= base_q + word_idx;
          wr_data_o    <= word_c;
          word_count_o <= word_count_o + ADDRS_WIDTH'(1);
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_memory_writer.sv
// Scoreboard bench for weight_memory_writer: expected writes are queued as the
// stream is driven and matched against writes seen on the memory port.
module tb_weight_memory_writer;

  localparam int unsigned N = 9;
  localparam int unsigned F = 8;
  localparam int unsigned A = 10;
  localparam int unsigned W = N * F;

  logic         clk_i = 1'b0;
  logic         rd_weight_rst = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [A-1:0] base_addr_i = '0;
  logic [A-1:0] n_words_i = '0;
  logic [F-1:0] w_data_i = '0;
  logic         w_valid_i = 1'b0;
  logic         w_ready_o;
  logic         wr_en_o;
  logic [A-1:0] wr_addr_o;
  logic [W-1:0] wr_data_o;
  logic         busy_o;
  logic         done_o;
  logic [A-1:0] word_count_o;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic [A-1:0] cnt;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  ready_cnt = 0;
  bit  prev_wr = 1'b0;
  bit  consec = 1'b0;

  weight_memory_writer #(.N_ROWS_ARRAY(N), .F_WIDTH(F), .ADDRS_WIDTH(A)) dut (
    .clk_i        (clk_i),
    .rd_weight_rst(rd_weight_rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .base_addr_i  (base_addr_i),
    .n_words_i    (n_words_i),
    .w_data_i     (w_data_i),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .word_count_o (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // Passive monitor: records writes, done pulses and ready cycles.
  always @(negedge clk_i) begin
    wr_t m;
    if (wr_en_o) begin
      m.cyc  = 32'(cyc);
      m.addr = wr_addr_o;
      m.data = wr_data_o;
      m.cnt  = word_count_o;
      obs_q.push_back(m);
    end
    if (wr_en_o && prev_wr) consec = 1'b1;
    prev_wr = wr_en_o;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (w_ready_o) ready_cnt++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_session(input logic [A-1:0] base, input logic [A-1:0] n, output int s);
    s = cyc;
    start_i = 1'b1;
    base_addr_i = base;
    n_words_i = n;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int b = 0;
    while (busy_o && b < 50) begin
      step();
      b++;
    end
    ok = !busy_o;
  endtask

  // Drives weights and models packing; pushes expected writes to exp_q.
  task automatic stream(input logic [F-1:0] ws[$], input logic [A-1:0] base, input bit bubbles,
                        input int stop_after, input bit do_abort, input int glitch_at);
    int lane = 0;
    int widx = 0;
    int n_acc = 0;
    int i = 0;
    int budget = 0;
    int c0;
    bit tog = 1'b1;
    bit rdy;
    logic [W-1:0] acc = '0;
    wr_t e;
    while (i < ws.size() && budget < 1000) begin
      budget++;
      if (n_acc == stop_after && !do_abort) break;
      w_data_i  = ws[i];
      w_valid_i = bubbles ? tog : 1'b1;
      tog = !tog;
      abort_i = do_abort && (n_acc == stop_after);
      start_i = (n_acc == glitch_at);
      if (start_i) begin
        base_addr_i = 10'h200;
        n_words_i   = 10'd5;
      end
      rdy = w_ready_o;
      c0  = cyc;
      step();
      start_i = 1'b0;
      if (abort_i) begin
        abort_i = 1'b0;
        break;
      end
      if (w_valid_i && rdy) begin
        acc[lane*F +: F] = ws[i];
        i++;
        n_acc++;
        if (lane == N - 1) begin
          e.cyc  = 32'(c0 + 1);
          e.addr = A'(int'(base) + widx);
          e.data = acc;
          e.cnt  = A'(widx + 1);
          exp_q.push_back(e);
          lane = 0;
          widx++;
        end else begin
          lane++;
        end
      end
    end
    w_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rd_weight_rst = 1'b1;
    step();
    step();
    vectors++;
    if ({w_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got ready=%b en=%b busy=%b done=%b addr=%h data=%h cnt=%h exp all 0",
               w_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o);
    end
    rd_weight_rst = 1'b0;
    step();
  endtask

  task automatic test_two_words();
    logic [F-1:0] ws[$];
    int s, d0;
    bit ok;
    wr_t e, o;
    for (int k = 1; k <= 18; k++) ws.push_back(F'(k));
    d0 = done_cnt;
    start_session(10'h010, 10'd2, s);
    stream(ws, 10'h010, 1'b0, -1, 1'b0, -1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL two_words timeout busy=%b exp 0", busy_o); end
    vectors++;
    if (exp_q.size() != 2 || exp_q[0].cyc != 32'(s + 10) || exp_q[1].cyc != 32'(s + 19)) begin
      miscompares++;
      $display("FAIL two_words model_cycles got n=%0d exp 2 words at %0d,%0d", exp_q.size(), s + 10, s + 19);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL two_words write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL two_words write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL two_words extra_writes got %0d exp 0", obs_q.size()); obs_q.delete(); end
    vectors++;
    if (done_cnt != d0 + 1 || done_cyc != s + 20) begin
      miscompares++; $display("FAIL two_words done got n=%0d cyc=%0d exp n=1 cyc=%0d", done_cnt - d0, done_cyc, s + 20);
    end
    vectors++;
    if (word_count_o !== 10'd2) begin miscompares++; $display("FAIL two_words count got %0d exp 2", word_count_o); end
  endtask

  task automatic test_bubbles();
    logic [F-1:0] ws[$] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic [W-1:0] got = '0;
    int s;
    bit ok;
    wr_t e, o;
    start_session(10'h030, 10'd1, s);
    stream(ws, 10'h030, 1'b1, -1, 1'b0, -1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bubbles timeout busy=%b exp 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL bubbles write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        got = o.data;
        if (o !== e) begin
          miscompares++;
          $display("FAIL bubbles write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL bubbles extra_writes got %0d exp 0", obs_q.size()); obs_q.delete(); end
    vectors++;
    if (got[23:0] !== 24'hFF7F80) begin miscompares++; $display("FAIL bubbles lanes got %h exp ff7f80", got[23:0]); end
  endtask

  task automatic test_wrap();
    logic [F-1:0] ws[$];
    int s, d0;
    bit ok;
    wr_t e, o;
    for (int k = 0; k < 18; k++) ws.push_back(F'($urandom_range(0, 255)));
    d0 = done_cnt;
    start_session(10'h3FF, 10'd2, s);
    stream(ws, 10'h3FF, 1'b0, -1, 1'b0, -1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wrap timeout busy=%b exp 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL wrap write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL wrap write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL wrap extra_writes got %0d exp 0", obs_q.size()); obs_q.delete(); end
    vectors++;
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL wrap done_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_zero_and_ignored_start();
    logic [F-1:0] ws[$];
    int s, d0, r0;
    bit ok;
    wr_t e, o;
    d0 = done_cnt;
    r0 = ready_cnt;
    start_session(10'h123, 10'd0, s);
    wait_idle(ok);
    vectors++;
    if (!ok || done_cnt != d0 + 1 || done_cyc != s + 1) begin
      miscompares++; $display("FAIL zero_words done got n=%0d cyc=%0d exp n=1 cyc=%0d", done_cnt - d0, done_cyc, s + 1);
    end
    vectors++;
    if (obs_q.size() != 0 || ready_cnt != r0 || word_count_o !== '0) begin
      miscompares++;
      $display("FAIL zero_words activity got writes=%0d ready=%0d cnt=%0d exp 0,0,0", obs_q.size(), ready_cnt - r0, word_count_o);
      obs_q.delete();
    end
    for (int k = 0; k < 9; k++) ws.push_back(F'(8'hA0 + k));
    d0 = done_cnt;
    start_session(10'h100, 10'd1, s);
    stream(ws, 10'h100, 1'b0, -1, 1'b0, 3);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ignored_start timeout busy=%b exp 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL ignored_start write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL ignored_start write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0 || done_cnt != d0 + 1 || word_count_o !== 10'd1) begin
      miscompares++;
      $display("FAIL ignored_start session got extra=%0d done=%0d cnt=%0d exp 0,1,1", obs_q.size(), done_cnt - d0, word_count_o);
      obs_q.delete();
    end
  endtask

  task automatic test_abort();
    logic [F-1:0] ws[$];
    logic [F-1:0] ws2[$];
    logic [W-1:0] got = '0;
    int s, d0;
    bit ok;
    wr_t e, o;
    for (int k = 0; k < 27; k++) ws.push_back(F'(8'h40 + k));
    d0 = done_cnt;
    start_session(10'h040, 10'd3, s);
    stream(ws, 10'h040, 1'b0, 13, 1'b1, -1);
    vectors++;
    if (busy_o !== 1'b0 || w_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL abort idle got busy=%b ready=%b exp 0,0", busy_o, w_ready_o);
    end
    step();
    step();
    vectors++;
    if (word_count_o !== 10'd1 || done_cnt != d0) begin
      miscompares++; $display("FAIL abort state got cnt=%0d done=%0d exp 1,0", word_count_o, done_cnt - d0);
    end
    for (int k = 0; k < 9; k++) ws2.push_back(F'(8'hC1 + k));
    start_session(10'h020, 10'd1, s);
    stream(ws2, 10'h020, 1'b0, -1, 1'b0, -1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL abort timeout busy=%b exp 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL abort write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        got = o.data;
        if (o !== e) begin
          miscompares++;
          $display("FAIL abort write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL abort extra_writes got %0d exp 0", obs_q.size()); obs_q.delete(); end
    vectors++;
    if (got[7:0] !== 8'hC1) begin miscompares++; $display("FAIL abort next_lane0 got %h exp c1", got[7:0]); end
  endtask

  task automatic test_async_reset();
    logic [F-1:0] ws[$];
    logic [F-1:0] ws2[$];
    int s, d0;
    bit ok;
    wr_t e, o;
    for (int k = 0; k < 18; k++) ws.push_back(F'(8'h10 + k));
    d0 = done_cnt;
    start_session(10'h2A0, 10'd2, s);
    stream(ws, 10'h2A0, 1'b0, 14, 1'b0, -1);
    #2;
    rd_weight_rst = 1'b1;
    #1;
    vectors++;
    if ({w_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset outputs got ready=%b en=%b busy=%b done=%b addr=%h data=%h cnt=%h exp all 0",
               w_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o);
    end
    step();
    step();
    rd_weight_rst = 1'b0;
    step();
    for (int k = 0; k < 9; k++) ws2.push_back(F'(8'hE0 + k));
    start_session(10'h055, 10'd1, s);
    stream(ws2, 10'h055, 1'b0, -1, 1'b0, -1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL async_reset timeout busy=%b exp 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL async_reset write missing exp addr=%h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL async_reset write got cyc=%0d addr=%h data=%h cnt=%0d exp cyc=%0d addr=%h data=%h cnt=%0d",
                   o.cyc, o.addr, o.data, o.cnt, e.cyc, e.addr, e.data, e.cnt);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0 || done_cnt != d0 + 1) begin
      miscompares++; $display("FAIL async_reset tail got extra=%0d done=%0d exp 0,1", obs_q.size(), done_cnt - d0);
      obs_q.delete();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_two_words();
    test_bubbles();
    test_wrap();
    test_zero_and_ignored_start();
    test_abort();
    test_async_reset();
    vectors++;
    if (consec) begin miscompares++; $display("FAIL back_to_back_wr_en got consecutive strobes exp none"); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
